// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared VGA constants for the timing generator, the sprite fetch unit and the
// pixel mixer: active raster size, raster counter width and the colour type.
// ----------------------------------------------------------------------------
package vga_pkg;
    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;
    localparam int CNT_W       = 10;
    localparam int PIX_COLOR_W = 3;

    typedef logic [CNT_W-1:0]       count_t;
    typedef logic [PIX_COLOR_W-1:0] color_t;
endpackage

// File: rtl/sprite_pos_reg.sv
// ----------------------------------------------------------------------------
// sprite_pos_reg
// Double-buffered sprite origin. pos_load captures pos_x/pos_y into a shadow
// and marks it pending; the pending shadow becomes active at the frame commit
// cycle (hcount==0, vcount==V_ACTIVE) and pos_ack pulses once. The armed flag
// goes high at the first commit after reset and qualifies sprite output.
// Optional macro SPRITE_HFLIP_EN adds hflip, buffered alongside the position.
// Ports:
//   vga_clk, reset       pixel clock, synchronous active-high reset
//   hcount, vcount       raster position (used only to detect commit)
//   pos_x, pos_y         requested origin, pos_load 1-cycle capture strobe
//   hflip / act_flip_r   (SPRITE_HFLIP_EN) requested / active mirror flag
//   act_x_r, act_y_r     active origin
//   armed_r              high once a commit has been seen since reset
//   commit_s             combinational commit-cycle indicator
//   pos_ack              1-cycle pulse when a pending shadow goes active
// ----------------------------------------------------------------------------
module sprite_pos_reg
    import vga_pkg::*;
(
    input  logic             vga_clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] hcount,
    input  logic [CNT_W-1:0] vcount,
    input  logic [CNT_W-1:0] pos_x,
    input  logic [CNT_W-1:0] pos_y,
    input  logic             pos_load,
`ifdef SPRITE_HFLIP_EN
    input  logic             hflip,
    output logic             act_flip_r,
`endif
    output logic [CNT_W-1:0] act_x_r,
    output logic [CNT_W-1:0] act_y_r,
    output logic             armed_r,
    output logic             commit_s,
    output logic             pos_ack
);

    logic [CNT_W-1:0] shadow_x_r;
    logic [CNT_W-1:0] shadow_y_r;
    logic             pending_r;
`ifdef SPRITE_HFLIP_EN
    logic             shadow_flip_r;
`endif

    // Commit happens at the first blanking line after the active area.
    assign commit_s = (hcount == {CNT_W{1'b0}}) && (vcount == CNT_W'(V_ACTIVE));

    // Shadow/active position registers and commit handshake.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            shadow_x_r <= {CNT_W{1'b0}};
            shadow_y_r <= {CNT_W{1'b0}};
            act_x_r    <= {CNT_W{1'b0}};
            act_y_r    <= {CNT_W{1'b0}};
            pending_r  <= 1'b0;
            armed_r    <= 1'b0;
            pos_ack    <= 1'b0;
`ifdef SPRITE_HFLIP_EN
            shadow_flip_r <= 1'b0;
            act_flip_r    <= 1'b0;
`endif
        end else begin
            pos_ack <= commit_s && pending_r;
            if (commit_s) begin
                armed_r <= 1'b1;
            end
            // The commit always takes the shadow as it stood before this edge,
            // so a load landing on the commit cycle waits for the next frame.
            if (commit_s && pending_r) begin
                act_x_r <= shadow_x_r;
                act_y_r <= shadow_y_r;
`ifdef SPRITE_HFLIP_EN
                act_flip_r <= shadow_flip_r;
`endif
            end
            if (pos_load) begin
                shadow_x_r <= pos_x;
                shadow_y_r <= pos_y;
                pending_r  <= 1'b1;
`ifdef SPRITE_HFLIP_EN
                shadow_flip_r <= hflip;
`endif
            end else if (commit_s) begin
                pending_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sprite_addr_gen.sv
// ----------------------------------------------------------------------------
// sprite_addr_gen
// Sprite fetch unit: from the raster position computes the sprite ROM address
// of the pixel under the beam at a movable, clipped origin, then qualifies the
// returned ROM colour with hit and colour-key transparency.
// Pipeline: raster at edge t -> rom_addr at t+1 -> pix_color/pix_valid at t+2.
// Optional macro SPRITE_HFLIP_EN adds the hflip input (horizontal mirror).
// Ports:
//   vga_clk, reset       pixel clock, synchronous active-high reset
//   hcount, vcount       raster position from the timing generator
//   pos_x, pos_y, pos_load  new origin and its capture strobe
//   hflip                (SPRITE_HFLIP_EN) mirror flag, captured with pos_load
//   pos_ack              pulse when a pending origin becomes active
//   rom_addr             registered sprite ROM address (holds when no hit)
//   rom_data             ROM data, one cycle after rom_addr
//   pix_color, pix_valid registered colour and opacity for the mixer
// ----------------------------------------------------------------------------
module sprite_addr_gen
    import vga_pkg::*;
#(
    parameter int               SPR_W      = 82,
    parameter int               SPR_H      = 123,
    parameter int               ADDR_W     = 14,
    parameter int               COLOR_W    = 3,
    parameter logic [COLOR_W-1:0] TRANSP_KEY = {COLOR_W{1'b0}}
) (
    input  logic               vga_clk,
    input  logic               reset,
    input  logic [CNT_W-1:0]   hcount,
    input  logic [CNT_W-1:0]   vcount,
    input  logic [CNT_W-1:0]   pos_x,
    input  logic [CNT_W-1:0]   pos_y,
    input  logic               pos_load,
`ifdef SPRITE_HFLIP_EN
    input  logic               hflip,
`endif
    output logic               pos_ack,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic [COLOR_W-1:0] pix_color,
    output logic               pix_valid
);

    localparam int EXT_W = CNT_W + 1;

    logic [CNT_W-1:0]  act_x_s;
    logic [CNT_W-1:0]  act_y_s;
    logic              armed_s;
    logic              commit_s;
    logic              act_flip_s;
    logic              col_hit_s;
    logic              row_hit_s;
    logic              hit_s;
    logic              line_end_s;
    logic [CNT_W-1:0]  col_s;
    logic [CNT_W-1:0]  off_s;
    logic [ADDR_W-1:0] addr_next_s;
    logic [ADDR_W-1:0] row_base_r;
    logic              hit_d1_r;
    logic              hit_d2_r;

    sprite_pos_reg u_pos (
        .vga_clk  (vga_clk),
        .reset    (reset),
        .hcount   (hcount),
        .vcount   (vcount),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .pos_load (pos_load),
`ifdef SPRITE_HFLIP_EN
        .hflip    (hflip),
        .act_flip_r (act_flip_s),
`endif
        .act_x_r  (act_x_s),
        .act_y_r  (act_y_s),
        .armed_r  (armed_s),
        .commit_s (commit_s),
        .pos_ack  (pos_ack)
    );

`ifndef SPRITE_HFLIP_EN
    assign act_flip_s = 1'b0;
`endif

    // Hit test and address arithmetic; one extra bit keeps origin+size from wrapping.
    always_comb begin
        col_hit_s = ({1'b0, hcount} >= {1'b0, act_x_s})
                 && ({1'b0, hcount} <  ({1'b0, act_x_s} + EXT_W'(SPR_W)))
                 && ({1'b0, hcount} <  EXT_W'(H_ACTIVE));
        row_hit_s = ({1'b0, vcount} >= {1'b0, act_y_s})
                 && ({1'b0, vcount} <  ({1'b0, act_y_s} + EXT_W'(SPR_H)))
                 && ({1'b0, vcount} <  EXT_W'(V_ACTIVE));
        hit_s      = col_hit_s && row_hit_s;
        line_end_s = (hcount == CNT_W'(H_ACTIVE));
        col_s      = hcount - act_x_s;
        if (act_flip_s) begin
            off_s = CNT_W'(SPR_W - 1) - col_s;
        end else begin
            off_s = col_s;
        end
        addr_next_s = row_base_r + ADDR_W'(off_s);
    end

    // Row base accumulator, address register and two-stage output pipeline.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            row_base_r <= {ADDR_W{1'b0}};
            rom_addr   <= {ADDR_W{1'b0}};
            hit_d1_r   <= 1'b0;
            hit_d2_r   <= 1'b0;
            pix_valid  <= 1'b0;
            pix_color  <= {COLOR_W{1'b0}};
        end else begin
            // Row base steps by one sprite row at the first blanking column of
            // every line the sprite covered, replacing a row*SPR_W multiply.
            if (commit_s) begin
                row_base_r <= {ADDR_W{1'b0}};
            end else if (line_end_s && row_hit_s) begin
                row_base_r <= row_base_r + ADDR_W'(SPR_W);
            end
            if (hit_s) begin
                rom_addr <= addr_next_s;
            end
            hit_d1_r <= hit_s && armed_s;
            hit_d2_r <= hit_d1_r;
            if (hit_d2_r && (rom_data != TRANSP_KEY)) begin
                pix_valid <= 1'b1;
                pix_color <= rom_data;
            end else begin
                pix_valid <= 1'b0;
                pix_color <= {COLOR_W{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_sprite_addr_gen.sv
`timescale 1ns/1ps
// Self-checking bench for sprite_addr_gen: drives a compressed raster (only the
// interesting columns of each line plus the line-end column 640), keeps a
// behavioural model of the sprite address/pixel stream and compares each cycle.
module tb_sprite_addr_gen;
    localparam int SPR_W   = 82;
    localparam int SPR_H   = 123;
    localparam int ADDR_W  = 14;
    localparam int COLOR_W = 3;
    localparam int ROM_N   = 16384;
`ifdef SPRITE_HFLIP_EN
    localparam bit FLIP_EN = 1'b1;
`else
    localparam bit FLIP_EN = 1'b0;
`endif

    logic               vga_clk  = 1'b0;
    logic               reset    = 1'b1;
    logic [9:0]         hcount   = 10'd0;
    logic [9:0]         vcount   = 10'd0;
    logic [9:0]         pos_x    = 10'd0;
    logic [9:0]         pos_y    = 10'd0;
    logic               pos_load = 1'b0;
    logic               hflip    = 1'b0;
    logic               pos_ack;
    logic [ADDR_W-1:0]  rom_addr;
    logic [COLOR_W-1:0] rom_data = 3'd0;
    logic [COLOR_W-1:0] pix_color;
    logic               pix_valid;
    logic [COLOR_W-1:0] rom_mem [ROM_N];

    int total = 0;
    int bad   = 0;

    // Reference model state
    int                 m_ax = 0, m_ay = 0, m_sx = 0, m_sy = 0;
    bit                 m_pend = 0, m_armed = 0, m_flip = 0, m_sflip = 0;
    logic [ADDR_W-1:0]  m_addr = '0, p1_addr = '0, p2_addr = '0;
    bit                 p1_hit = 0, p2_hit = 0;
    logic               e_pv = 1'b0, e_ack = 1'b0;
    logic [COLOR_W-1:0] e_pc = 3'd0;

    sprite_addr_gen #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W), .TRANSP_KEY(3'd0)
    ) dut (
        .vga_clk   (vga_clk),
        .reset     (reset),
        .hcount    (hcount),
        .vcount    (vcount),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .pos_load  (pos_load),
`ifdef SPRITE_HFLIP_EN
        .hflip     (hflip),
`endif
        .pos_ack   (pos_ack),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .pix_color (pix_color),
        .pix_valid (pix_valid)
    );

    always #5 vga_clk = ~vga_clk;

    // Synchronous sprite ROM
    always @(posedge vga_clk) rom_data <= rom_mem[rom_addr];

    // Drive one raster position for one clock and advance the model.
    task automatic step(input int h, input int v);
        bit hit, commit;
        int off;
        hcount = 10'(h);
        vcount = 10'(v);
        @(posedge vga_clk);
        if (reset) begin
            m_ax = 0; m_ay = 0; m_sx = 0; m_sy = 0;
            m_pend = 0; m_armed = 0; m_flip = 0; m_sflip = 0;
            m_addr = '0; p1_addr = '0; p2_addr = '0; p1_hit = 0; p2_hit = 0;
            e_pv = 1'b0; e_pc = 3'd0; e_ack = 1'b0;
        end else begin
            e_pv = p2_hit && (rom_mem[p2_addr] != 3'd0);
            e_pc = e_pv ? rom_mem[p2_addr] : 3'd0;
            p2_hit = p1_hit; p2_addr = p1_addr;
            hit = (h >= m_ax) && (h < m_ax + SPR_W) && (h < 640)
               && (v >= m_ay) && (v < m_ay + SPR_H) && (v < 480);
            if (hit) begin
                off = m_flip ? (SPR_W - 1 - (h - m_ax)) : (h - m_ax);
                m_addr = ADDR_W'((v - m_ay) * SPR_W + off);
            end
            p1_hit = hit && m_armed; p1_addr = m_addr;
            commit = (h == 0) && (v == 480);
            e_ack = commit && m_pend;
            if (commit) m_armed = 1;
            if (commit && m_pend) begin m_ax = m_sx; m_ay = m_sy; m_flip = m_sflip; end
            if (pos_load) begin
                m_sx = int'(pos_x); m_sy = int'(pos_y); m_sflip = FLIP_EN && hflip; m_pend = 1;
            end else if (commit) begin
                m_pend = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(7, 7);
        step(8, 7);
        total += 4;
        if (rom_addr !== 14'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", rom_addr); end
        if (pix_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", pix_valid); end
        if (pix_color !== 3'd0) begin bad++; $display("FAIL reset_color got=%0d exp=0", pix_color); end
        if (pos_ack !== 1'b0)   begin bad++; $display("FAIL reset_ack got=%0b exp=0", pos_ack); end
        reset = 1'b0;
    endtask

    task automatic test_unarmed();
        for (int h = 0; h <= 12; h++) begin
            step(h, 0);
            total += 2;
            if (pix_valid !== 1'b0) begin bad++; $display("FAIL unarmed_valid h=%0d got=%0b exp=0", h, pix_valid); end
            if (rom_addr !== m_addr) begin bad++; $display("FAIL unarmed_addr h=%0d got=%0d exp=%0d", h, rom_addr, m_addr); end
        end
        step(0, 480);
        total++;
        if (pos_ack !== 1'b0) begin bad++; $display("FAIL unarmed_ack got=%0b exp=0", pos_ack); end
        step(1, 480);
    endtask

    task automatic test_default_frame();
        int h;
        for (int v = 0; v <= 123; v++) begin
            for (int i = 0; i <= 85; i++) begin
                h = (i == 85) ? 640 : i;
                step(h, v);
                total += 2;
                if (rom_addr !== m_addr) begin bad++; $display("FAIL dflt_addr h=%0d v=%0d got=%0d exp=%0d", h, v, rom_addr, m_addr); end
                if (pix_valid !== e_pv || pix_color !== e_pc) begin
                    bad++; $display("FAIL dflt_pix h=%0d v=%0d got=%0b/%0d exp=%0b/%0d", h, v, pix_valid, pix_color, e_pv, e_pc);
                end
                if (h == 81 && v == 122) begin
                    total++;
                    if (rom_addr !== 14'd10085) begin bad++; $display("FAIL dflt_last got=%0d exp=10085", rom_addr); end
                end
                if (h == 0 && v == 1) begin
                    total++;
                    if (rom_addr !== 14'd82) begin bad++; $display("FAIL dflt_line1 got=%0d exp=82", rom_addr); end
                end
                if (h == 84 && v == 0) begin
                    total++;
                    if (pix_valid !== 1'b0) begin bad++; $display("FAIL dflt_col82 got=%0b exp=0", pix_valid); end
                end
                if (h == 7 && v == 0) begin
                    total++;
                    if (pix_valid !== 1'b0) begin bad++; $display("FAIL transp_key got=%0b exp=0", pix_valid); end
                end
                if (h == 6 && v == 0) begin
                    total++;
                    if (pix_valid !== 1'b1 || pix_color !== rom_mem[4]) begin
                        bad++; $display("FAIL opaque_col4 got=%0b/%0d exp=1/%0d", pix_valid, pix_color, rom_mem[4]);
                    end
                end
            end
        end
        step(0, 480);
        total++;
        if (pos_ack !== e_ack) begin bad++; $display("FAIL dflt_ack got=%0b exp=%0b", pos_ack, e_ack); end
        step(1, 480);
    endtask

    task automatic test_pos_load();
        int h;
        for (int v = 0; v <= 130; v++) begin
            for (int i = 0; i <= 4; i++) begin
                h = (i == 4) ? 640 : i;
                if (v == 2 && i == 1) begin pos_x = 10'd7; pos_y = 10'd3; pos_load = 1'b1; end
                else if (v == 4 && i == 2) begin pos_x = 10'd100; pos_y = 10'd50; pos_load = 1'b1; end
                else pos_load = 1'b0;
                step(h, v);
                total++;
                if (rom_addr !== m_addr || pix_valid !== e_pv || pos_ack !== 1'b0) begin
                    bad++; $display("FAIL load_hold h=%0d v=%0d got=%0d/%0b/%0b exp=%0d/%0b/0", h, v, rom_addr, pix_valid, pos_ack, m_addr, e_pv);
                end
                if (h == 0 && v == 10) begin
                    total++;
                    if (rom_addr !== 14'd820) begin bad++; $display("FAIL load_oldpos got=%0d exp=820", rom_addr); end
                end
            end
        end
        pos_load = 1'b0;
        step(0, 480);
        total++;
        if (pos_ack !== 1'b1 || e_ack !== 1'b1) begin bad++; $display("FAIL load_ack got=%0b exp=1", pos_ack); end
        step(1, 480);
        total++;
        if (pos_ack !== 1'b0) begin bad++; $display("FAIL load_ack_pulse got=%0b exp=0", pos_ack); end
        for (int v = 48; v <= 175; v++) begin
            for (int i = 0; i <= 6; i++) begin
                h = (i == 6) ? 640 : 98 + i;
                step(h, v);
                total += 2;
                if (rom_addr !== m_addr) begin bad++; $display("FAIL moved_addr h=%0d v=%0d got=%0d exp=%0d", h, v, rom_addr, m_addr); end
                if (pix_valid !== e_pv || pix_color !== e_pc) begin
                    bad++; $display("FAIL moved_pix h=%0d v=%0d got=%0b/%0d exp=%0b/%0d", h, v, pix_valid, pix_color, e_pv, e_pc);
                end
                if (h == 100 && v == 50) begin
                    total++;
                    if (rom_addr !== 14'd0) begin bad++; $display("FAIL moved_origin got=%0d exp=0", rom_addr); end
                end
            end
        end
        step(0, 480);
        total++;
        if (pos_ack !== 1'b0) begin bad++; $display("FAIL moved_noack got=%0b exp=0", pos_ack); end
        step(1, 480);
    endtask

    task automatic test_clip();
        pos_x = 10'd600; pos_y = 10'd450; pos_load = 1'b1;
        step(3, 481);
        pos_load = 1'b0;
        step(0, 480);
        step(1, 480);
        for (int v = 446; v <= 479; v++) begin
            for (int h = 596; h <= 700; h++) begin
                step(h, v);
                total += 2;
                if (rom_addr !== m_addr) begin bad++; $display("FAIL clip_addr h=%0d v=%0d got=%0d exp=%0d", h, v, rom_addr, m_addr); end
                if (pix_valid !== e_pv || pix_color !== e_pc) begin
                    bad++; $display("FAIL clip_pix h=%0d v=%0d got=%0b/%0d exp=%0b/%0d", h, v, pix_valid, pix_color, e_pv, e_pc);
                end
                if (h == 600 && v == 451) begin
                    total++;
                    if (rom_addr !== 14'd82) begin bad++; $display("FAIL clip_line1 got=%0d exp=82", rom_addr); end
                end
                if (h == 660 && v == 479) begin
                    total++;
                    if (rom_addr !== 14'd2417) begin bad++; $display("FAIL clip_edge got=%0d exp=2417", rom_addr); end
                end
            end
        end
        step(0, 480);
        step(1, 480);
    endtask

    task automatic test_back_to_back();
        pos_x = 10'd20; pos_y = 10'd30; pos_load = 1'b1;
        step(5, 470);
        pos_x = 10'd40; pos_y = 10'd60; pos_load = 1'b1;
        step(0, 480);
        pos_load = 1'b0;
        total++;
        if (pos_ack !== 1'b1) begin bad++; $display("FAIL b2b_ack1 got=%0b exp=1", pos_ack); end
        step(1, 480);
        step(20, 30);
        total++;
        if (rom_addr !== 14'd0 || rom_addr !== m_addr) begin bad++; $display("FAIL b2b_first got=%0d exp=0", rom_addr); end
        step(0, 480);
        total++;
        if (pos_ack !== 1'b1) begin bad++; $display("FAIL b2b_ack2 got=%0b exp=1", pos_ack); end
        step(1, 480);
        step(40, 60);
        total++;
        if (rom_addr !== 14'd0 || rom_addr !== m_addr) begin bad++; $display("FAIL b2b_second got=%0d exp=0", rom_addr); end
        step(0, 480);
        total++;
        if (pos_ack !== 1'b0) begin bad++; $display("FAIL b2b_ack3 got=%0b exp=0", pos_ack); end
        step(1, 480);
    endtask

    task automatic test_reset_midframe();
        int h;
        pos_x = 10'd0; pos_y = 10'd150; pos_load = 1'b1;
        step(3, 481);
        pos_load = 1'b0;
        step(0, 480);
        step(1, 480);
        for (int v = 150; v <= 260; v++) begin
            for (int i = 0; i <= 4; i++) begin
                h = (i == 4) ? 640 : i;
                reset = (v == 200 && i == 0);
                step(h, v);
                total += 2;
                if (rom_addr !== m_addr) begin bad++; $display("FAIL rstmid_addr h=%0d v=%0d got=%0d exp=%0d", h, v, rom_addr, m_addr); end
                if (pix_valid !== e_pv || (v >= 200 && pix_valid !== 1'b0)) begin
                    bad++; $display("FAIL rstmid_pix h=%0d v=%0d got=%0b exp=%0b", h, v, pix_valid, e_pv);
                end
            end
        end
        reset = 1'b0;
        step(0, 480);
        total++;
        if (pos_ack !== 1'b0) begin bad++; $display("FAIL rstmid_ack got=%0b exp=0", pos_ack); end
        step(1, 480);
        for (int v = 0; v <= 1; v++) begin
            for (int i = 0; i <= 85; i++) begin
                h = (i == 85) ? 640 : i;
                step(h, v);
                total += 2;
                if (rom_addr !== m_addr) begin bad++; $display("FAIL resume_addr h=%0d v=%0d got=%0d exp=%0d", h, v, rom_addr, m_addr); end
                if (pix_valid !== e_pv || pix_color !== e_pc) begin
                    bad++; $display("FAIL resume_pix h=%0d v=%0d got=%0b/%0d exp=%0b/%0d", h, v, pix_valid, pix_color, e_pv, e_pc);
                end
            end
        end
        step(0, 480);
        step(1, 480);
    endtask

`ifdef SPRITE_HFLIP_EN
    task automatic test_hflip();
        pos_x = 10'd0; pos_y = 10'd0; hflip = 1'b1; pos_load = 1'b1;
        step(3, 481);
        pos_load = 1'b0;
        step(0, 480);
        step(1, 480);
        for (int h = 0; h <= 81; h++) begin
            step(h, 0);
            total++;
            if (rom_addr !== 14'(81 - h)) begin bad++; $display("FAIL hflip_l0 h=%0d got=%0d exp=%0d", h, rom_addr, 81 - h); end
        end
        step(640, 0);
        step(0, 1);
        total++;
        if (rom_addr !== 14'd163) begin bad++; $display("FAIL hflip_l1s got=%0d exp=163", rom_addr); end
        step(81, 1);
        total++;
        if (rom_addr !== 14'd82) begin bad++; $display("FAIL hflip_l1e got=%0d exp=82", rom_addr); end
        step(0, 480);
        step(1, 480);
    endtask
`endif

    task automatic test_random();
        int px, py, lo, hi, vlast, h;
        for (int it = 0; it < 4; it++) begin
            px = $urandom_range(630, 0);
            py = $urandom_range(470, 0);
            hflip = 1'($urandom_range(1, 0));
            pos_x = 10'(px); pos_y = 10'(py); pos_load = 1'b1;
            step(4, 481);
            pos_load = 1'b0;
            step(0, 480);
            total++;
            if (pos_ack !== 1'b1) begin bad++; $display("FAIL rand_ack it=%0d got=%0b exp=1", it, pos_ack); end
            step(1, 480);
            lo = (px >= 2) ? px - 2 + $urandom_range(20, 0) : $urandom_range(20, 0);
            hi = lo + $urandom_range(12, 3);
            if (hi > 639) hi = 639;
            if (lo > hi) lo = hi;
            vlast = (py + SPR_H > 479) ? 479 : py + SPR_H;
            for (int v = py; v <= vlast; v++) begin
                for (int i = lo; i <= hi + 1; i++) begin
                    h = (i == hi + 1) ? 640 : i;
                    step(h, v);
                    total += 2;
                    if (rom_addr !== m_addr) begin bad++; $display("FAIL rand_addr h=%0d v=%0d got=%0d exp=%0d", h, v, rom_addr, m_addr); end
                    if (pix_valid !== e_pv || pix_color !== e_pc) begin
                        bad++; $display("FAIL rand_pix h=%0d v=%0d got=%0b/%0d exp=%0b/%0d", h, v, pix_valid, pix_color, e_pv, e_pc);
                    end
                end
            end
        end
        hflip = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < ROM_N; i++) begin
            rom_mem[i] = 3'($urandom_range(7, 1));
            if (i >= 200 && ($urandom_range(15, 0) == 0)) rom_mem[i] = 3'd0;
        end
        rom_mem[5] = 3'd0;
        test_reset();
        test_unarmed();
        test_default_frame();
        test_pos_load();
        test_clip();
        test_back_to_back();
        test_reset_midframe();
`ifdef SPRITE_HFLIP_EN
        test_hflip();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_addr_gen.md
# sprite_addr_gen

Parametrised sprite fetch unit between the VGA timing generator and a sprite ROM. From the raster position it computes the ROM address of the sprite pixel under the beam, at a runtime-movable origin. It returns a registered colour with valid/transparency qualification for the pixel mixer. Generalises the fixed top-left, fixed-size sprite addressing to arbitrary size, position, clipping and colour-key transparency.

## Interface
- SPR_W, 82, sprite width in pixels (1..H_ACTIVE)
- SPR_H, 123, sprite height in lines (1..V_ACTIVE)
- ADDR_W, 14, ROM address width; must satisfy SPR_W*SPR_H <= 2**ADDR_W
- COLOR_W, 3, ROM pixel width
- TRANSP_KEY, 0, colour treated as transparent
- vga_clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- hcount  in  10  horizontal count from timing generator (active 0..H_ACTIVE-1)
- vcount  in  10  vertical count (active 0..V_ACTIVE-1)
- pos_x  in  10  requested sprite left column
- pos_y  in  10  requested sprite top line
- pos_load  in  1  1-cycle strobe capturing pos_x/pos_y into shadow
- pos_ack  out  1  1-cycle pulse when a pending shadow position becomes active
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  COLOR_W  ROM read data, valid one cycle after rom_addr
- pix_color  out  COLOR_W  registered sprite colour
- pix_valid  out  1  1 = sprite pixel opaque at this position

## Operation
- Hit: hcount in [act_x, act_x+SPR_W) and vcount in [act_y, act_y+SPR_H), with hcount<H_ACTIVE and vcount<V_ACTIVE. Comparisons use 11-bit sums, so no wrap occurs; sprites partly or fully off-screen are clipped.
- Address = row_base + col. col = hcount-act_x. row_base is 0 on frame commit and advances by SPR_W at hcount==H_ACTIVE on each line where the row hit. No multiplier.
- rom_addr holds its last value when there is no hit.
- pix_valid = registered hit AND rom_data != TRANSP_KEY. pix_color = rom_data when valid, else 0.
- Position double-buffer:
  - pos_load writes the shadow and sets pending.
  - Commit cycle: hcount==0 and vcount==V_ACTIVE. On commit with pending, active <= shadow, pending clears, and pos_ack pulses.
  - pos_load on the commit cycle is written to the shadow only. The current commit uses the prior shadow, and the new value commits at the next frame.
  - Repeated loads before commit: last one wins, with a single pos_ack.
- armed flag: cleared by reset, set on the first commit cycle. pix_valid is forced 0 while not armed.

## Timing
- Latency: hcount/vcount sampled at edge t → rom_addr at t+1 → pix_color/pix_valid at t+2. The timing generator delays hsync/vsync by 2 to align.
- Throughput: one pixel per vga_clk.
- Reset values: rom_addr=0, pix_color=0, pix_valid=0, pos_ack=0, active and shadow positions=0, pending=0, armed=0, row_base=0.
- Reset mid-frame: output stays blank until the next commit cycle, then renders normally.
- SPR_W ending exactly at H_ACTIVE-1: the last column is rendered. The line-end row_base update still occurs at hcount==H_ACTIVE.

## Configuration
- SPRITE_HFLIP_EN defined: adds input hflip (1 bit). hflip is double-buffered with pos_load and committed with the position. When set, address = row_base + (SPR_W-1-col).
- SPRITE_HFLIP_EN undefined: no hflip port; address = row_base + col.

## Structure
- Shared package vga_pkg holds H_ACTIVE=640, V_ACTIVE=480, the count width (10) and the colour typedef. It is shared with the timing generator and mixer.
- One sub-module, sprite_pos_reg, holds the shadow, pending flag, commit logic and pos_ack. The address and pipeline logic stay in the top.

## Test plan
- Defaults, origin (0,0), no load: after the first frame commit, the line-0 pixels at hcount 0..81 give rom_addr 0..81. Line 1 starts at 82. Line 122, col 81 gives 10085. pix_valid is 0 at hcount 82.
- pos_load (100,50) mid-frame: position is unchanged for the rest of the frame. pos_ack pulses at (0,480). Next frame, the first rom_addr=0 occurs for hcount=100, vcount=50.
- Clipping, origin (600,450): only cols 0..39 and lines 0..29 are fetched. Line 1 starts at address 82. There is no hit at hcount≥640.
- Transparency: ROM returns 0 at address 5 and non-zero elsewhere. pix_valid=0 exactly 2 cycles after the raster reaches col 5. Elsewhere, pix_valid=1 with the ROM value.
- Reset asserted at vcount=200: pix_valid stays 0 through the end of that frame. Rendering resumes at origin (0,0) after commit.
- SPRITE_HFLIP_EN, hflip=1: line 0 addresses run 81 down to 0, and line 1 runs 163 down to 82.
